// File: rtl/awgn_stats_monitor.sv
// rtl/awgn_stats_monitor.sv - windowed mean / mean-square / peak-magnitude monitor for a noise sample stream
module awgn_stats_monitor #(
    parameter int LOG2_WIN = 10
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] sample_in,
    input  logic        sample_valid,
    output logic [15:0] mean_out,
    output logic [31:0] power_out,
    output logic [15:0] peak_out,
    output logic        busy,
    output logic        done
);

    localparam int SUM_W = 16 + LOG2_WIN;
    localparam int SQ_W  = 31 + LOG2_WIN;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FINAL = 2'd2
    } state_t;

    state_t                   r_state;
    logic signed [SUM_W-1:0]  r_sum;
    logic        [SQ_W-1:0]   r_sumsq;
    logic [LOG2_WIN-1:0]      r_count;
    logic        [15:0]       r_peak;
    logic        [15:0]       r_mean;
    logic        [31:0]       r_power;
    logic        [15:0]       r_peak_out;
    logic                     r_busy;
    logic                     r_done;

    logic signed [15:0]       w_sample;
    logic signed [31:0]       w_sq_full;
    logic        [15:0]       w_abs;
    logic signed [SUM_W-1:0]  w_sample_ext;
    logic        [SQ_W-1:0]   w_sq_ext;
    logic signed [SUM_W-1:0]  w_mean_full;
    logic        [SQ_W-1:0]   w_power_full;

    assign w_sample     = sample_in;
    assign w_sq_full    = w_sample * w_sample;
    // Two's-complement negate of 0x8000 yields 0x8000, which reads as 32768 unsigned.
    assign w_abs        = sample_in[15] ? (~sample_in + 16'd1) : sample_in;
    assign w_sample_ext = {{LOG2_WIN{sample_in[15]}}, sample_in};
    assign w_sq_ext     = {{LOG2_WIN{1'b0}}, w_sq_full[30:0]};
    assign w_mean_full  = r_sum >>> LOG2_WIN;
    assign w_power_full = r_sumsq >> LOG2_WIN;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state    <= IDLE;
            r_sum      <= '0;
            r_sumsq    <= '0;
            r_count    <= '0;
            r_peak     <= '0;
            r_mean     <= '0;
            r_power    <= '0;
            r_peak_out <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_sum   <= '0;
                        r_sumsq <= '0;
                        r_count <= '0;
                        r_peak  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (abort) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (sample_valid) begin
                        r_sum   <= r_sum + w_sample_ext;
                        r_sumsq <= r_sumsq + w_sq_ext;
                        r_count <= r_count + 1'b1;
                        if (w_abs > r_peak) begin
                            r_peak <= w_abs;
                        end
                        if (&r_count) begin
                            r_state <= FINAL;
                        end
                    end
                end
                FINAL: begin
                    r_mean     <= w_mean_full[15:0];
                    r_power    <= {1'b0, w_power_full[30:0]};
                    r_peak_out <= r_peak;
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mean_out  = r_mean;
    assign power_out = r_power;
    assign peak_out  = r_peak_out;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_awgn_stats_monitor.sv
// tb/tb_awgn_stats_monitor.sv - directed self-checking bench for awgn_stats_monitor with a 4-sample window
module tb_awgn_stats_monitor;

    logic        clk;
    logic        n_reset;
    logic        start;
    logic        abort;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic [15:0] mean_out;
    logic [31:0] power_out;
    logic [15:0] peak_out;
    logic        busy;
    logic        done;

    int checks;
    int errors;

    awgn_stats_monitor #(.LOG2_WIN(2)) dut (
        .clk          (clk),
        .n_reset      (n_reset),
        .start        (start),
        .abort        (abort),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .mean_out     (mean_out),
        .power_out    (power_out),
        .peak_out     (peak_out),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs just after an edge, then advance through the next edge and settle.
    task automatic step(input logic s, input logic a, input logic v, input logic [15:0] d);
        start        = s;
        abort        = a;
        sample_valid = v;
        sample_in    = d;
        @(posedge clk);
        #1;
    endtask

    task automatic feed4(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] d);
        step(0, 0, 1, a);
        step(0, 0, 1, b);
        step(0, 0, 1, c);
        step(0, 0, 1, d);
    endtask

    task automatic test_reset;
        n_reset = 1'b0;
        #1;
        checks++;
        if ({mean_out, power_out, peak_out, busy, done} !== 66'd0) begin
            errors++;
            $display("FAIL reset_outputs: got mean=%h power=%h peak=%h busy=%b done=%b required all 0",
                     mean_out, power_out, peak_out, busy, done);
        end
        #12;
        n_reset = 1'b1;
        step(0, 0, 1, 16'd1000);
        step(0, 1, 1, 16'd2000);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignores_samples: got busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    task automatic test_basic;
        step(1, 0, 1, 16'd5000);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy_after_start: got %b required 1", busy);
        end
        feed4(16'd100, 16'd200, -16'sd300, 16'd400);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL basic_final_state: got busy=%b done=%b required 1 0", busy, done);
        end
        step(0, 0, 0, 16'd0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: got done=%b busy=%b required 1 0", done, busy);
        end
        checks++;
        if (mean_out !== 16'd100 || power_out !== 32'd75000 || peak_out !== 16'd400) begin
            errors++;
            $display("FAIL basic_results: got mean=%0d power=%0d peak=%0d required 100 75000 400",
                     $signed(mean_out), power_out, peak_out);
        end
        step(0, 0, 0, 16'd0);
        checks++;
        if (done !== 1'b0 || mean_out !== 16'd100) begin
            errors++;
            $display("FAIL basic_done_clears: got done=%b mean=%0d required 0 100", done, $signed(mean_out));
        end
    endtask

    task automatic test_extreme;
        step(1, 0, 0, 16'd0);
        feed4(16'h8000, 16'h8000, 16'h8000, 16'h8000);
        step(0, 0, 0, 16'd0);
        checks++;
        if (done !== 1'b1 || mean_out !== 16'h8000 || power_out !== 32'd1073741824 || peak_out !== 16'd32768) begin
            errors++;
            $display("FAIL extreme_results: got done=%b mean=%h power=%0d peak=%0d required 1 8000 1073741824 32768",
                     done, mean_out, power_out, peak_out);
        end
    endtask

    task automatic test_floor;
        step(1, 0, 0, 16'd0);
        feed4(16'hFFFF, 16'd0, 16'd0, 16'd0);
        step(0, 0, 0, 16'd0);
        checks++;
        if (done !== 1'b1 || mean_out !== 16'hFFFF || power_out !== 32'd0 || peak_out !== 16'd1) begin
            errors++;
            $display("FAIL floor_results: got done=%b mean=%h power=%0d peak=%0d required 1 ffff 0 1",
                     done, mean_out, power_out, peak_out);
        end
    endtask

    task automatic test_gaps;
        logic [15:0] samp [4];
        int          gap  [4];
        int          dones;
        int          done_edge;
        int          edge_no;
        samp[0] = 16'd100; samp[1] = 16'd200; samp[2] = -16'sd300; samp[3] = 16'd400;
        gap[0] = 0; gap[1] = 3; gap[2] = 1; gap[3] = 2;
        dones = 0;
        done_edge = -1;
        edge_no = 0;
        step(1, 0, 0, 16'd0);
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < gap[i]; g++) begin
                step(g[0], 0, 0, 16'd7777);
                edge_no++;
                if (done === 1'b1) dones++;
            end
            step(0, 0, 1, samp[i]);
            edge_no++;
            if (done === 1'b1) dones++;
        end
        for (int j = 0; j < 4; j++) begin
            step(0, 0, 0, 16'd0);
            edge_no++;
            if (done === 1'b1) begin
                dones++;
                if (done_edge < 0) done_edge = j;
            end
            if (j == 0) begin
                checks++;
                if (mean_out !== 16'd100 || power_out !== 32'd75000 || peak_out !== 16'd400) begin
                    errors++;
                    $display("FAIL gaps_results: got mean=%0d power=%0d peak=%0d required 100 75000 400",
                             $signed(mean_out), power_out, peak_out);
                end
            end
        end
        checks++;
        if (dones !== 1 || done_edge !== 0) begin
            errors++;
            $display("FAIL gaps_done_once: got %0d pulses at offset %0d required 1 at offset 0", dones, done_edge);
        end
    endtask

    task automatic test_abort;
        step(1, 0, 0, 16'd0);
        step(0, 0, 1, 16'd5);
        step(0, 0, 1, 16'd6);
        step(0, 1, 1, 16'd7);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: got busy=%b done=%b required 0 0", busy, done);
        end
        step(0, 0, 1, 16'd8);
        checks++;
        if (done !== 1'b0 || mean_out !== 16'd100 || power_out !== 32'd75000 || peak_out !== 16'd400) begin
            errors++;
            $display("FAIL abort_retain: got done=%b mean=%0d power=%0d peak=%0d required 0 100 75000 400",
                     done, $signed(mean_out), power_out, peak_out);
        end
        step(1, 1, 1, 16'd9);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_with_start: got busy=%b required 1", busy);
        end
        feed4(16'd1, 16'd2, 16'd3, 16'd4);
        step(0, 1, 0, 16'd0);
        checks++;
        if (done !== 1'b1 || mean_out !== 16'd2 || power_out !== 32'd7 || peak_out !== 16'd4) begin
            errors++;
            $display("FAIL abort_next_window: got done=%b mean=%0d power=%0d peak=%0d required 1 2 7 4",
                     done, $signed(mean_out), power_out, peak_out);
        end
    endtask

    task automatic test_reset_mid;
        int dones;
        dones = 0;
        step(1, 0, 0, 16'd0);
        step(0, 0, 1, 16'd50);
        step(0, 0, 1, 16'd60);
        #2;
        n_reset = 1'b0;
        #1;
        checks++;
        if ({mean_out, power_out, peak_out, busy, done} !== 66'd0) begin
            errors++;
            $display("FAIL reset_mid_clear: got mean=%h power=%h peak=%h busy=%b done=%b required all 0",
                     mean_out, power_out, peak_out, busy, done);
        end
        #1;
        n_reset = 1'b1;
        for (int j = 0; j < 4; j++) begin
            step(0, 0, 1, 16'd70);
            if (done === 1'b1 || busy === 1'b1) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL reset_mid_no_done: got %0d active cycles required 0", dones);
        end
    endtask

    task automatic test_back_to_back;
        step(1, 0, 0, 16'd0);
        feed4(16'd100, 16'd200, -16'sd300, 16'd400);
        step(0, 0, 0, 16'd0);
        checks++;
        if (done !== 1'b1 || mean_out !== 16'd100) begin
            errors++;
            $display("FAIL b2b_first: got done=%b mean=%0d required 1 100", done, $signed(mean_out));
        end
        step(1, 0, 0, 16'd0);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_start_in_done: got busy=%b done=%b required 1 0", busy, done);
        end
        feed4(16'hFFFF, 16'd0, 16'd0, 16'd0);
        step(0, 0, 0, 16'd0);
        checks++;
        if (done !== 1'b1 || mean_out !== 16'hFFFF || power_out !== 32'd0 || peak_out !== 16'd1) begin
            errors++;
            $display("FAIL b2b_second: got done=%b mean=%h power=%0d peak=%0d required 1 ffff 0 1",
                     done, mean_out, power_out, peak_out);
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        start        = 1'b0;
        abort        = 1'b0;
        sample_valid = 1'b0;
        sample_in    = 16'd0;
        test_reset();
        test_basic();
        test_extreme();
        test_floor();
        test_basic();
        test_gaps();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/awgn_stats_monitor.md
AWGN_STATS_MONITOR -- requirements
Module: awgn_stats_monitor

Interface
REQ-001 The block SHALL have parameter LOG2_WIN, default 10: the window is 2^LOG2_WIN samples; the legal range is 1..16.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port n_reset, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin one measurement window.
REQ-005 The block SHALL have port abort, input, 1 bit: cancels a running window.
REQ-006 The block SHALL have port sample_in, input, 16 bits: signed two's-complement noise sample, the generator's noise output.
REQ-007 The block SHALL have port sample_valid, input, 1 bit: sample_in is valid this cycle (the generator's enable).
REQ-008 The block SHALL have port mean_out, output, 16 bits: signed window mean.
REQ-009 The block SHALL have port power_out, output, 32 bits: unsigned mean of squares.
REQ-010 The block SHALL have port peak_out, output, 16 bits: unsigned maximum |sample| in the window.
REQ-011 The block SHALL have port busy, output, 1 bit: a window is in progress.
REQ-012 The block SHALL have port done, output, 1 bit: a one-cycle pulse marking new results.

Function
REQ-013 The block SHALL implement FSM states IDLE, ACCUM and FINAL.
REQ-014 In IDLE, start=1 SHALL clear the sum, sum-of-squares, sample count and peak, and enter ACCUM at the next edge.
REQ-015 The sample present in the start cycle SHALL be ignored.
REQ-016 busy SHALL be 1 exactly while the state is ACCUM or FINAL.
REQ-017 In ACCUM, each edge with sample_valid=1 SHALL add sample_in to a signed (16+LOG2_WIN)-bit sum.
REQ-018 On the same edge, sample_in^2 SHALL be added to an unsigned (31+LOG2_WIN)-bit sum-of-squares.
REQ-019 On the same edge, the count SHALL increment and peak SHALL be updated to max(peak, |sample_in|); |-32768| = 32768.
REQ-020 Edges with sample_valid=0 SHALL leave all accumulators unchanged; gaps of any length are allowed.
REQ-021 When the 2^LOG2_WIN-th sample is accepted (edge k), the state SHALL go to FINAL at edge k.
REQ-022 At edge k+1, the block SHALL register mean_out = sum arithmetically shifted right by LOG2_WIN (floor toward minus infinity).
REQ-023 At edge k+1, the block SHALL register power_out = sum-of-squares shifted right by LOG2_WIN, and peak_out = peak.
REQ-024 At edge k+1, done SHALL go to 1, busy to 0 and the state to IDLE; done SHALL return to 0 at edge k+2.
REQ-025 Accumulators SHALL never overflow at the sized widths, and there is no saturation logic.
REQ-026 mean_out, power_out and peak_out SHALL hold their values until the next completed window.
REQ-027 start while busy=1 SHALL be ignored.
REQ-028 start in the cycle done=1 (state IDLE) SHALL be accepted and begin a new window.
REQ-029 sample_valid in IDLE SHALL be ignored.
REQ-030 abort=1 in ACCUM SHALL return the block to IDLE at the next edge without a done pulse, leaving the outputs unchanged.
REQ-031 abort SHALL take priority over sample acceptance in that cycle.
REQ-032 abort in IDLE or FINAL SHALL have no effect.
REQ-033 abort and start asserted together in IDLE SHALL start a window.

Reset
REQ-034 n_reset=0 SHALL immediately force state IDLE and all accumulators, mean_out, power_out, peak_out, busy and done to 0, regardless of clk.
REQ-035 Reset mid-window SHALL discard the window and produce no done pulse.
REQ-036 After n_reset rises, the block SHALL await start and need no other initialization.

Verification (LOG2_WIN=2, window 4)
REQ-037 Basic window: start, then valid samples 100, 200, -300, 400 -> one cycle after the 4th sample, done=1 with mean_out=100, power_out=75000, peak_out=400; busy=0.
REQ-038 Extreme values: four samples of -32768 -> mean_out=-32768, power_out=1073741824, peak_out=32768; no wrap.
REQ-039 Floor rounding: samples -1, 0, 0, 0 -> mean_out=-1, power_out=0, peak_out=1.
REQ-040 Gaps and ignored requests: sample_valid toggling with gaps of 0-3 cycles and start pulsed while busy -> results match the gapless run; done occurs exactly once, one cycle after the 4th accepted sample.
REQ-041 Abort: abort after 2 samples -> busy=0 next cycle, no done, outputs retain the previous window's values; a following full window completes normally.
REQ-042 Reset mid-window: n_reset pulsed low between edges mid-window -> outputs and busy 0 immediately; no done; back-to-back start in the done cycle runs a new correct window.
